// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device transmitter (open-drain enables)    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int CLK_HOLD_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       send_i,
  input  logic [7:0] tx_data_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int HOLD_W = (CLK_HOLD_CYCLES > 1) ? $clog2(CLK_HOLD_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(CLK_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_hold_pre  = HOLD_W'(CLK_HOLD_CYCLES - 2);
  localparam logic [TO_W-1:0]   c_to_pre    = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic              c_start_now = (CLK_HOLD_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RELEASE   = 3'd2,
    S_XMIT      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              clk_s1_q, clk_s2_q, clk_prev_q;
  logic              dat_s1_q, dat_s2_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [3:0]        bit_q, bit_d;
  logic [10:0]       sr_q, sr_d;
  logic              clk_oe_q, clk_oe_d;
  logic              dat_oe_q, dat_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_fall;
  logic              w_to_hit;

  // Synchronisers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign w_fall   = clk_prev_q & ~clk_s2_q;
  // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign w_to_hit = (to_q == c_to_pre);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    to_d     = to_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (send_i) begin
          sr_d     = {1'b1, ~^tx_data_i, tx_data_i, 1'b0};
          hold_d   = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = c_start_now;
          busy_d   = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (hold_q == c_hold_last) begin
          clk_oe_d = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          // Start bit goes out in the last held cycle.
          if (hold_q == c_hold_pre) begin
            dat_oe_d = ~sr_q[0];
          end
        end
      end

      S_RELEASE: begin
        to_d    = '0;
        bit_d   = 4'd0;
        state_d = S_XMIT;
      end

      S_XMIT, S_ACK, S_WAIT_IDLE: begin
        if (w_to_hit) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
          case (state_q)
            S_XMIT: begin
              if (w_fall) begin
                // sr_q[1] is the bit for this fall; the stop bit releases the line.
                bit_d    = bit_q + 4'd1;
                dat_oe_d = ~sr_q[1];
                sr_d     = {1'b1, sr_q[10:1]};
                if (bit_q == 4'd9) begin
                  state_d = S_ACK;
                end
              end
            end
            S_ACK: begin
              if (w_fall) begin
                bit_d = bit_q + 4'd1;
                if (!dat_s2_q) begin
                  state_d = S_WAIT_IDLE;
                end else begin
                  dat_oe_d = 1'b0;
                  busy_d   = 1'b0;
                  err_d    = 1'b1;
                  state_d  = S_IDLE;
                end
              end
            end
            default: begin
              if (clk_s2_q && dat_s2_q) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      to_q     <= '0;
      bit_q    <= 4'd0;
      sr_q     <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_host_tx : bench for ps2_host_tx with a PS/2 device model       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int H = 20;
  localparam int T = 4000;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_NOACK  = 2;
  localparam int M_ABORT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;
  logic       clk_oe, dat_oe, busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_rel = 0;
  int t_err = 0;
  int t_fall11 = 0;
  int dev_bit = 0;

  typedef struct {logic [7:0] data; logic ok;} exp_t;
  typedef struct {logic start; logic [7:0] data; logic par; logic stop;} frm_t;
  exp_t exp_q[$];
  frm_t cap_q[$];

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_line = ~(clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(.CLK_HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .send_i       (send),
    .tx_data_i    (tx_data),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_dat_i    (ps2_dat_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ref_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Scoreboard: every done/err pops one expected transfer.
  initial begin : mon
    exp_t e;
    frm_t f;
    forever begin
      @(negedge clk);
      if (!reset && (done || err)) begin
        if (err) t_err = cyc;
        chk("done_err_exclusive", 32'(done & err), 0);
        chk("busy_at_end", 32'(busy), 0);
        chk("clk_oe_at_end", 32'(clk_oe), 0);
        chk("dat_oe_at_end", 32'(dat_oe), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: done=%0b err=%0b with nothing pending", done, err);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_done", 32'(done), 32'(e.ok));
          if (e.ok && done) begin
            if (cap_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_missing: done with no frame captured for 0x%0h", e.data);
            end else begin
              f = cap_q.pop_front();
              chk("frame_start", 32'(f.start), 0);
              chk("frame_data", 32'(f.data), 32'(e.data));
              chk("frame_parity", 32'(f.par), 32'(ref_par(e.data)));
              chk("frame_stop", 32'(f.stop), 1);
            end
          end
        end
      end
    end
  end

  // Request-to-send window: clock held H cycles, start bit only in the last one.
  initial begin : inh
    int  run;
    int  first_dat;
    logic prev_oe;
    run = 0;
    first_dat = 0;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        first_dat = 0;
        prev_oe = 1'b0;
      end else begin
        if (clk_oe) begin
          run++;
          if (dat_oe && first_dat == 0) first_dat = run;
        end else if (prev_oe) begin
          chk("inhibit_len", 32'(run), H);
          chk("start_bit_cycle", 32'(first_dat), H);
          chk("release_dat_oe", 32'(dat_oe), 1);
          t_rel = cyc;
          run = 0;
          first_dat = 0;
        end
        prev_oe = clk_oe;
      end
    end
  end

  task automatic dev_run(input int mode);
    int n;
    logic [10:0] bits;
    frm_t f;
    dev_bit = 0;
    bits = '0;
    n = 0;
    while (ps2_clk_line !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL dev_no_inhibit: clock never pulled low within %0d cycles", n);
      return;
    end
    n = 0;
    while (ps2_clk_line !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL dev_no_release: clock still low after %0d cycles", n);
      return;
    end
    bits[0] = ps2_dat_line;
    chk("start_on_release", 32'(ps2_dat_line), 0);
    if (mode == M_SILENT) return;
    repeat (30 + $urandom_range(0, 20)) @(posedge clk);
    #1;
    for (int i = 1; i <= 11; i++) begin
      dev_bit = i;
      if (i == 11) begin
        t_fall11 = cyc;
        if (mode == M_NORMAL) dev_dat_low = 1'b1;
      end
      dev_clk_low = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      if (i <= 10) bits[i] = ps2_dat_line;
      dev_clk_low = 1'b0;
      if (i == 10 && mode == M_NORMAL) begin
        f.start = bits[0];
        f.data  = bits[8:1];
        f.par   = bits[9];
        f.stop  = bits[10];
        cap_q.push_back(f);
      end
      if (mode == M_ABORT && i == 5) return;
      if (i == 11) begin
        repeat (10) @(posedge clk);
        #1;
        dev_dat_low = 1'b0;
        repeat (40) @(posedge clk);
        #1;
      end else begin
        repeat (50) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic issue_send(input logic [7:0] d);
    @(posedge clk);
    #1;
    tx_data = d;
    send = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    tx_data = 8'($urandom);
    chk("busy_after_send", 32'(busy), 1);
  endtask

  task automatic xfer(input logic [7:0] d, input int mode);
    exp_t e;
    int n;
    e.data = d;
    e.ok = (mode == M_NORMAL);
    exp_q.push_back(e);
    issue_send(d);
    dev_run(mode);
    n = 0;
    while (busy !== 1'b0 && n < T + 500) begin @(posedge clk); #1; n++; end
    if (n >= T + 500) begin
      checks++; errors++;
      $display("FAIL busy_stuck: busy still high after %0d cycles", n);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int rb;
    int n;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_oe", 32'(clk_oe), 0);
    chk("rst_dat_oe", 32'(dat_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);

    xfer(8'hFF, M_NORMAL);
    xfer(8'hED, M_NORMAL);
    xfer(8'hF4, M_NORMAL);
    repeat (4) begin
      rb = $urandom;
      xfer(rb[7:0], M_NORMAL);
    end

    rb = $urandom;
    xfer(rb[7:0], M_SILENT);
    chk("timeout_latency", 32'(t_err - t_rel), T);

    rb = $urandom;
    xfer(rb[7:0], M_NOACK);
    chk("noack_err_latency", 32'((t_err - t_fall11 >= 2) && (t_err - t_fall11 <= 4)), 1);

    rb = $urandom;
    fork
      xfer(rb[7:0], M_NORMAL);
      begin
        repeat (400) @(posedge clk);
        #1;
        chk("busy_mid_xmit", 32'(busy), 1);
        tx_data = 8'h00;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
      end
    join

    issue_send(8'hA5);
    fork
      dev_run(M_ABORT);
      begin
        n = 0;
        while (dev_bit != 5 && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) begin
          checks++; errors++;
          $display("FAIL abort_no_bit5: device never reached bit 5");
        end
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_clk_oe", 32'(clk_oe), 0);
        chk("midrst_dat_oe", 32'(dat_oe), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    repeat (200) @(posedge clk);
    #1;
    xfer(8'hF4, M_NORMAL);

    repeat (20) @(posedge clk);
    #1;
    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    chk("cap_queue_empty", 32'(cap_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
